// File: rtl/serial_word_packer.sv
// Serial-to-parallel word packer: MSB-first bit stream into Width-bit words, double-buffered output.
// Optional even-parity trailer bit per word when SERIAL_WORD_PACKER_PARITY_EN is defined.
module serial_word_packer #(
  parameter int Width      = 8,
  parameter int CountWidth = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  output logic                  bit_ready,
  input  logic                  flush,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [Width-1:0]      word,
  output logic                  word_err,
  output logic [CountWidth-1:0] fill
);

`ifdef SERIAL_WORD_PACKER_PARITY_EN
  localparam int N = Width + 1;
`else
  localparam int N = Width;
`endif

  localparam logic [CountWidth-1:0] LastFill = CountWidth'(N - 1);

  typedef enum logic {
    COLLECT,
    FULL
  } state_t;

  state_t                  state_reg, state_next;
  logic [Width-1:0]        sreg_reg, sreg_next;
  logic [CountWidth-1:0]   fill_reg, fill_next;
  logic [Width-1:0]        word_reg, word_next;
  logic                    word_valid_reg, word_valid_next;
  logic                    word_err_reg, word_err_next;

  logic                    take;
  logic                    last;
  logic                    slot_free;
  logic [Width-1:0]        sreg_shift;
  logic [Width-1:0]        done_word;
  logic                    done_err;
  logic                    shift_en;
  logic                    full_err;

`ifdef SERIAL_WORD_PACKER_PARITY_EN
  logic par_reg, par_next;
  logic pend_err_reg, pend_err_next;

  // Last accepted bit is the parity bit, so the data is already complete in sreg.
  assign shift_en  = take && (fill_reg < CountWidth'(Width));
  assign done_word = sreg_reg;
  assign done_err  = par_reg ^ bit_in;
  assign full_err  = pend_err_reg;
`else
  assign shift_en  = take;
  assign done_word = sreg_shift;
  assign done_err  = 1'b0;
  assign full_err  = 1'b0;
`endif

  // A bit presented together with flush is dropped.
  assign take       = bit_valid && (state_reg == COLLECT) && !flush;
  assign last       = take && (fill_reg == LastFill);
  assign slot_free  = !word_valid_reg || word_ready;
  assign sreg_shift = {sreg_reg[Width-2:0], bit_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= COLLECT;
      sreg_reg       <= '0;
      fill_reg       <= '0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
      word_err_reg   <= 1'b0;
`ifdef SERIAL_WORD_PACKER_PARITY_EN
      par_reg        <= 1'b0;
      pend_err_reg   <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      sreg_reg       <= sreg_next;
      fill_reg       <= fill_next;
      word_reg       <= word_next;
      word_valid_reg <= word_valid_next;
      word_err_reg   <= word_err_next;
`ifdef SERIAL_WORD_PACKER_PARITY_EN
      par_reg        <= par_next;
      pend_err_reg   <= pend_err_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    sreg_next       = sreg_reg;
    fill_next       = fill_reg;
    word_next       = word_reg;
    word_valid_next = word_valid_reg;
    word_err_next   = word_err_reg;
`ifdef SERIAL_WORD_PACKER_PARITY_EN
    par_next        = par_reg;
    pend_err_next   = pend_err_reg;
`endif

    // A consumed word drops valid unless a new word is loaded below.
    if (word_ready) begin
      word_valid_next = 1'b0;
    end

    if (shift_en) begin
      sreg_next = sreg_shift;
    end

    if (flush) begin
      fill_next  = '0;
      state_next = COLLECT;
`ifdef SERIAL_WORD_PACKER_PARITY_EN
      par_next   = 1'b0;
`endif
    end else begin
      unique case (state_reg)
        COLLECT: begin
          if (take) begin
            fill_next = fill_reg + 1'b1;
`ifdef SERIAL_WORD_PACKER_PARITY_EN
            par_next  = par_reg ^ bit_in;
`endif
          end
          if (last) begin
`ifdef SERIAL_WORD_PACKER_PARITY_EN
            par_next = 1'b0;
`endif
            if (slot_free) begin
              word_next       = done_word;
              word_valid_next = 1'b1;
              word_err_next   = done_err;
              fill_next       = '0;
            end else begin
              state_next = FULL;
`ifdef SERIAL_WORD_PACKER_PARITY_EN
              pend_err_next = done_err;
`endif
            end
          end
        end
        FULL: begin
          if (slot_free) begin
            word_next       = sreg_reg;
            word_valid_next = 1'b1;
            word_err_next   = full_err;
            fill_next       = '0;
            state_next      = COLLECT;
          end
        end
        default: begin
          state_next = COLLECT;
        end
      endcase
    end
  end

  assign bit_ready  = (state_reg == COLLECT);
  assign word_valid = word_valid_reg;
  assign word       = word_reg;
  assign word_err   = word_err_reg;
  assign fill       = fill_reg;

endmodule

// File: tb/tb_serial_word_packer.sv
// Directed self-checking bench for serial_word_packer; honours SERIAL_WORD_PACKER_PARITY_EN.
module tb_serial_word_packer;

`ifdef SERIAL_WORD_PACKER_PARITY_EN
  localparam int N = 9;
`else
  localparam int N = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_valid;
  logic       bit_in;
  logic       bit_ready;
  logic       flush;
  logic       word_valid;
  logic       word_ready;
  logic [7:0] word;
  logic       word_err;
  logic [3:0] fill;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_word_packer #(.Width(8), .CountWidth(4)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .flush(flush), .word_valid(word_valid), .word_ready(word_ready), .word(word),
    .word_err(word_err), .fill(fill)
  );

  // Bit i of the serial sequence for word w: data MSB first, then even parity (optionally inverted).
  function automatic logic seq_bit(input logic [7:0] w, input int i, input logic flip);
    if (i < 8) return w[7-i];
    return (^w) ^ flip;
  endfunction

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int lo, input int hi, input logic flip);
    for (int i = lo; i < hi; i++) send_bit(seq_bit(w, i, flip));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; flush = 1'b0; word_ready = 1'b0;
    idle(2);
    checks++; if (word !== 8'h00) begin failures++; $display("FAIL reset_word: got %h expected 00", word); end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", word_valid); end
    checks++; if (word_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", word_err); end
    checks++; if (fill !== 4'd0) begin failures++; $display("FAIL reset_fill: got %0d expected 0", fill); end
    checks++; if (bit_ready !== 1'b1) begin failures++; $display("FAIL reset_bit_ready: got %b expected 1", bit_ready); end
    rst = 1'b1;
    idle(1);
    send_bits(8'h5A, 0, N, 1'b0);
    send_bits(8'hFF, 0, 5, 1'b0);
    checks++; if (fill !== 4'd5) begin failures++; $display("FAIL reset_prefill: got %0d expected 5", fill); end
    checks++; if (word_valid !== 1'b1 || word !== 8'h5A) begin
      failures++; $display("FAIL reset_pending: got valid=%b word=%h expected 1/5a", word_valid, word); end
    #2 rst = 1'b0;
    #1;
    checks++; if (word !== 8'h00 || word_valid !== 1'b0 || fill !== 4'd0 || bit_ready !== 1'b1 || word_err !== 1'b0) begin
      failures++; $display("FAIL async_reset: got word=%h valid=%b fill=%0d ready=%b err=%b expected 00/0/0/1/0",
                           word, word_valid, fill, bit_ready, word_err); end
    @(posedge clk); #1;
    rst = 1'b1;
    word_ready = 1'b1;
    send_bits(8'hC3, 0, N, 1'b0);
    checks++; if (word_valid !== 1'b1 || word !== 8'hC3) begin
      failures++; $display("FAIL reset_clean_word: got valid=%b word=%h expected 1/c3", word_valid, word); end
    $display("test_reset: word=%h after release", word);
    idle(1);
  endtask

  task automatic test_single_word;
    word_ready = 1'b1;
    send_bits(8'hA5, 0, N-1, 1'b0);
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %b expected 0", word_valid); end
    send_bits(8'hA5, N-1, N, 1'b0);
    checks++; if (word_valid !== 1'b1 || word !== 8'hA5) begin
      failures++; $display("FAIL single_word: got valid=%b word=%h expected 1/a5", word_valid, word); end
    checks++; if (fill !== 4'd0 || word_err !== 1'b0) begin
      failures++; $display("FAIL single_fill_err: got fill=%0d err=%b expected 0/0", fill, word_err); end
    idle(1);
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL single_consume: got %b expected 0", word_valid); end
    $display("test_single_word: word=a5 delivered");
  endtask

  task automatic test_back_pressure;
    word_ready = 1'b0;
    send_bits(8'hA5, 0, N, 1'b0);
    checks++; if (word_valid !== 1'b1 || word !== 8'hA5 || fill !== 4'd0) begin
      failures++; $display("FAIL bp_first: got valid=%b word=%h fill=%0d expected 1/a5/0", word_valid, word, fill); end
    send_bits(8'h3C, 0, N, 1'b0);
    checks++; if (fill !== 4'(N) || bit_ready !== 1'b0 || word !== 8'hA5) begin
      failures++; $display("FAIL bp_full: got fill=%0d ready=%b word=%h expected %0d/0/a5", fill, bit_ready, word, N); end
    send_bit(1'b1);
    checks++; if (fill !== 4'(N) || bit_ready !== 1'b0) begin
      failures++; $display("FAIL bp_hold: got fill=%0d ready=%b expected %0d/0", fill, bit_ready, N); end
    word_ready = 1'b1;
    idle(1);
    word_ready = 1'b0;
    checks++; if (word !== 8'h3C || word_valid !== 1'b1 || bit_ready !== 1'b1 || fill !== 4'd0) begin
      failures++; $display("FAIL bp_release: got word=%h valid=%b ready=%b fill=%0d expected 3c/1/1/0",
                           word, word_valid, bit_ready, fill); end
    idle(1);
    checks++; if (word_valid !== 1'b1 || word !== 8'h3C) begin
      failures++; $display("FAIL bp_held: got valid=%b word=%h expected 1/3c", word_valid, word); end
    word_ready = 1'b1;
    idle(1);
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got %b expected 0", word_valid); end
    $display("test_back_pressure: a5 then 3c delivered");
  endtask

  task automatic test_flush;
    word_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    checks++; if (fill !== 4'd3) begin failures++; $display("FAIL flush_prefill: got %0d expected 3", fill); end
    flush = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bit_valid = 1'b0;
    checks++; if (fill !== 4'd0) begin failures++; $display("FAIL flush_fill: got %0d expected 0", fill); end
    send_bits(8'hFF, 0, N, 1'b0);
    checks++; if (word_valid !== 1'b1 || word !== 8'hFF) begin
      failures++; $display("FAIL flush_word: got valid=%b word=%h expected 1/ff", word_valid, word); end
    idle(1);
    word_ready = 1'b0;
    send_bits(8'hA5, 0, N, 1'b0);
    send_bits(8'h3C, 0, N, 1'b0);
    flush = 1'b1; word_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (fill !== 4'd0 || bit_ready !== 1'b1 || word_valid !== 1'b0 || word !== 8'hA5) begin
      failures++; $display("FAIL flush_full: got fill=%0d ready=%b valid=%b word=%h expected 0/1/0/a5",
                           fill, bit_ready, word_valid, word); end
    $display("test_flush: partial and full words discarded");
  endtask

  task automatic test_simultaneous;
    word_ready = 1'b0;
    send_bits(8'hA5, 0, N, 1'b0);
    send_bits(8'h3C, 0, N-1, 1'b0);
    word_ready = 1'b1;
    send_bits(8'h3C, N-1, N, 1'b0);
    checks++; if (word_valid !== 1'b1 || word !== 8'h3C || fill !== 4'd0) begin
      failures++; $display("FAIL simul_swap: got valid=%b word=%h fill=%0d expected 1/3c/0", word_valid, word, fill); end
    $display("test_simultaneous: a5 replaced by 3c without gap");
  endtask

  task automatic test_back_to_back;
    word_ready = 1'b1;
    send_bits(8'h96, 0, N, 1'b0);
    checks++; if (word_valid !== 1'b1 || word !== 8'h96) begin
      failures++; $display("FAIL b2b_first: got valid=%b word=%h expected 1/96", word_valid, word); end
    send_bits(8'h0F, 0, N, 1'b0);
    checks++; if (word_valid !== 1'b1 || word !== 8'h0F || bit_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_second: got valid=%b word=%h ready=%b expected 1/0f/1", word_valid, word, bit_ready); end
    idle(1);
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %b expected 0", word_valid); end
    $display("test_back_to_back: 96 and 0f delivered");
  endtask

  task automatic test_parity;
    word_ready = 1'b1;
    send_bits(8'hA5, 0, N, 1'b0);
    checks++; if (word_err !== 1'b0 || word !== 8'hA5) begin
      failures++; $display("FAIL parity_good: got err=%b word=%h expected 0/a5", word_err, word); end
    send_bits(8'hA5, 0, N, 1'b1);
`ifdef SERIAL_WORD_PACKER_PARITY_EN
    checks++; if (word_err !== 1'b1 || word !== 8'hA5) begin
      failures++; $display("FAIL parity_bad: got err=%b word=%h expected 1/a5", word_err, word); end
`else
    checks++; if (word_err !== 1'b0 || word !== 8'hA5) begin
      failures++; $display("FAIL parity_off: got err=%b word=%h expected 0/a5", word_err, word); end
`endif
    idle(1);
    $display("test_parity: err flag checked");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_pressure();
    test_flush();
    test_simultaneous();
    test_back_to_back();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_packer.md
# serial_word_packer

Serial-to-parallel word packer feeding the chromosome shift stage of the genetic datapath. Accepts a valid/ready bit stream, MSB-first, in the same order the shift buffer shifts in: left shift, new bit at the LSB. Assembles `Width`-bit words in a shift register and hands each completed word to a one-entry output register with a valid/ready handshake. The two stages are double-buffered, so collection continues while a finished word waits downstream.

## Interface
- `Width`, 8, word width in bits; legal range ≥ 2.
- `CountWidth`, 4, width of the fill counter; must satisfy 2^CountWidth > `Width` (+1 when parity is enabled).
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, asynchronous, active-low; one clock, no other reset.
- `bit_valid`  input  1  `bit_in` carries a bit this cycle.
- `bit_in`  input  1  serial data bit.
- `bit_ready`  output  1  packer accepts a bit this cycle.
- `flush`  input  1  discard the partially collected word.
- `word_valid`  output  1  `word` holds a completed word.
- `word_ready`  input  1  downstream consumes `word` this cycle.
- `word`  output  `Width`  completed word; first received bit is at `word[Width-1]`.
- `word_err`  output  1  parity error flag qualified by `word_valid`.
- `fill`  output  `CountWidth`  number of bits currently held in the shift register.

## Operation
- Bit transfer: `bit_valid && bit_ready` on a rising edge; `sreg <= {sreg[Width-2:0], bit_in}`, `fill <= fill+1`.
- States: COLLECT (fill < N), FULL (fill == N, waiting for output slot). N = `Width`, or `Width`+1 with parity.
- COLLECT→FULL when the Nth bit is accepted and the output slot cannot take it on that edge; otherwise the word moves straight to the output register and `fill` returns to 0 (no FULL cycle).
- Output slot is free when `!word_valid || word_ready`.
- FULL→COLLECT on the first edge the slot is free: transfer `sreg` to `word`, set `word_valid`, `fill <= 0`.
- `bit_ready` = 1 in COLLECT, 0 in FULL. It is combinational from state only, not from `word_ready`.
- `word_valid` clears on `word_ready` unless a new word is loaded on the same edge; if one is, it stays 1 with the new data.
- `flush` (COLLECT or FULL): `fill <= 0`, state COLLECT. A bit accepted in the flush cycle is dropped. `flush` has priority over the word transfer in the same cycle. The output register is untouched.
- Reset mid-operation discards the partial word and any pending output word.
- Reset values: `word` = 0, `word_valid` = 0, `word_err` = 0, `fill` = 0, `bit_ready` = 1 (state COLLECT), `sreg` = 0.

## Timing
- Latency: `word_valid` asserts the cycle after the edge accepting the last bit, provided the slot is free.
- Throughput: one bit per cycle sustained with `word_ready` held high; no bubble between words.
- Back-pressure: with `word_valid`=1 and `word_ready`=0, at most N more bits are accepted before `bit_ready` drops.
- No combinational path from inputs to outputs except `word_ready` → nothing; all outputs are registered or state-decoded.

## Configuration
- `SERIAL_WORD_PACKER_PARITY_EN` defined: each word is followed by one even-parity bit, so N = `Width`+1. The parity bit is not stored in `word`. `word_err` = XOR of all `Width`+1 received bits and is registered with `word`.
- Not defined: N = `Width`; `word_err` is tied to 0.

## Test plan
- Reset: drive `rst`=0 asynchronously mid-word with `fill`=5 -> all outputs immediately 0, `bit_ready`=1; after release, 8 new bits give a clean word.
- Single word: send bits 1,0,1,0,0,1,0,1 on consecutive cycles, `word_ready`=1 -> `word`=8'hA5, `word_valid`=1 exactly one cycle after the 8th bit; consumed next edge.
- Back-pressure: `word_ready`=0, stream 0xA5 then 0x3C continuously -> `word`=8'hA5 held, `fill`=8, `bit_ready`=0 after the 16th bit. Raise `word_ready` for 1 cycle -> `word`=8'h3C next cycle, `bit_ready`=1.
- Flush: send 1,1,1, then assert `flush` with `bit_valid`=1 -> `fill`=0. Then send eight 1s -> `word`=8'hFF.
- Simultaneous: `word_valid`=1 with `word_ready`=1 on the edge the 8th bit of the next word lands -> `word_valid` stays 1 and `word` updates with no gap.
- Parity (macro defined): 0xA5 + parity 0 -> `word_err`=0; 0xA5 + parity 1 -> `word_err`=1, `word`=8'hA5.
